// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN synapse front-end.
package snn_pkg;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned N_IN_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBoot = 2'd1,
    StScan = 2'd2
  } state_e;

endpackage

// File: rtl/synapse_weight_rf.sv
// Per-synapse weight store: one synchronous write port, one asynchronous read port, no reset.
module synapse_weight_rf
  import snn_pkg::*;
#(
  parameter int unsigned NIn   = N_IN_DEFAULT,
  parameter int unsigned AddrW = $clog2(NIn)
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [AddrW-1:0]         waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic [AddrW-1:0]         raddr_i,
  output logic signed [DATA_W-1:0] rdata_o
);

  logic signed [DATA_W-1:0] mem_q [NIn];

  // Addresses past the last synapse are silently dropped.
  always_ff @(posedge clk_i) begin
    if (we_i && (32'(waddr_i) < NIn)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/synapse_driver.sv
// Scans latched presynaptic spikes each timestep and streams matching weights to one neuron.
// Optional sticky overrun flag built when SYNAPSE_OVERRUN_FLAG_EN is defined.
module synapse_driver
  import snn_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEFAULT,
  parameter int unsigned ADDR_W = $clog2(N_IN)
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     snn_clk,
  input  logic                     boot_mode,
  input  logic [N_IN-1:0]          spikes_in,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     bias_load,
  output logic signed [DATA_W-1:0] dout,
  output logic                     data_ready,
  output logic                     boot_out,
  output logic                     busy,
  output logic                     overrun
);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [N_IN-1:0]          spikes_q, spikes_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                     dready_q, dready_d;
  logic                     boot_out_q, boot_out_d;

  logic                     rf_we;
  logic signed [DATA_W-1:0] rf_rdata;
  logic                     last_idx;
  logic                     tick_ok;
  logic                     boot_act;

  synapse_weight_rf #(
    .NIn   (N_IN),
    .AddrW (ADDR_W)
  ) u_weight_rf (
    .clk_i   (sys_clk),
    .we_i    (rf_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (idx_q),
    .rdata_o (rf_rdata)
  );

  assign last_idx   = (idx_q == ADDR_W'(N_IN - 1));
  assign tick_ok    = snn_clk && !boot_mode && (state_q != StBoot);
  assign boot_act   = (state_q == StBoot) && boot_mode;
  assign boot_out_d = boot_mode;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (boot_mode)    state_d = StBoot;
        else if (snn_clk) state_d = StScan;
      end
      StBoot: begin
        if (!boot_mode) state_d = StIdle;
      end
      StScan: begin
        if (boot_mode)     state_d = StBoot;
        else if (snn_clk)  state_d = StScan;
        else if (last_idx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    spikes_d = spikes_q;
    dout_d   = dout_q;
    dready_d = 1'b0;
    rf_we    = 1'b0;
    if (tick_ok) begin
      spikes_d = spikes_in;
      idx_d    = '0;
    end else if ((state_q == StScan) && !boot_mode) begin
      if (spikes_q[idx_q]) begin
        dready_d = 1'b1;
        dout_d   = rf_rdata;
      end
      idx_d = last_idx ? '0 : idx_q + 1'b1;
    end
    // Bias forwarding wins over a same-cycle weight write.
    if (boot_act) begin
      if (bias_load) begin
        dout_d   = wr_data;
        dready_d = 1'b1;
      end else begin
        rf_we = wr_en;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      spikes_q   <= '0;
      dout_q     <= '0;
      dready_q   <= 1'b0;
      boot_out_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      spikes_q   <= spikes_d;
      dout_q     <= dout_d;
      dready_q   <= dready_d;
      boot_out_q <= boot_out_d;
    end
  end

`ifdef SYNAPSE_OVERRUN_FLAG_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (boot_mode && !boot_out_q) begin
      overrun_d = 1'b0;
    end else if ((state_q == StScan) && tick_ok) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign dout       = dout_q;
  // A result registered just before a new timestep is suppressed so the
  // neuron never sees a qualifier in its tick cycle.
  assign data_ready = dready_q && !snn_clk;
  assign boot_out   = boot_out_q;
  assign busy       = (state_q == StScan);

endmodule

// File: tb/tb_synapse_driver.sv
// Bench for synapse_driver: N_IN=16 and N_IN=12 instances against a timestep-level model.
// Overrun expectations follow SYNAPSE_OVERRUN_FLAG_EN.
module tb_synapse_driver;

`ifdef SYNAPSE_OVERRUN_FLAG_EN
  localparam bit OvrEn = 1'b1;
`else
  localparam bit OvrEn = 1'b0;
`endif

  logic               sys_clk = 1'b0;
  logic               rst = 1'b1;
  logic               snn_clk = 1'b0;
  logic               boot_mode = 1'b0;
  logic [15:0]        spikes_in = '0;
  logic               wr_en = 1'b0;
  logic [3:0]         wr_addr = '0;
  logic signed [15:0] wr_data = '0;
  logic               bias_load = 1'b0;

  logic signed [15:0] dout0, dout1;
  logic dr0, dr1, bo0, bo1, busy0, busy1, ovr0, ovr1;

  always #5 sys_clk = ~sys_clk;

  synapse_driver #(.N_IN(16)) u_dut16 (
    .sys_clk(sys_clk), .rst(rst), .snn_clk(snn_clk), .boot_mode(boot_mode),
    .spikes_in(spikes_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bias_load(bias_load), .dout(dout0), .data_ready(dr0), .boot_out(bo0),
    .busy(busy0), .overrun(ovr0)
  );

  synapse_driver #(.N_IN(12)) u_dut12 (
    .sys_clk(sys_clk), .rst(rst), .snn_clk(snn_clk), .boot_mode(boot_mode),
    .spikes_in(spikes_in[11:0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bias_load(bias_load), .dout(dout1), .data_ready(dr1), .boot_out(bo1),
    .busy(busy1), .overrun(ovr1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  // Reference model, one slot per instance.
  int          nn [2] = '{16, 12};
  int          w [2][16];
  logic [15:0] lat [2];
  int          scan_pos [2];  // -1 when no timestep is being scanned
  bit          in_boot [2];
  int          m_dout [2];
  bit          m_dr [2];
  bit          m_bo [2];
  bit          m_ovr [2];

  int ev_cyc0[$], ev_val0[$], ev_cyc1[$], ev_val1[$];
  int busy_cnt;

  typedef struct {
    logic signed [15:0] wdata;
    int                 exp_dout;
  } bias_vec_t;
  bias_vec_t bt [4];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      in_boot[k] = 1'b0; scan_pos[k] = -1; lat[k] = '0;
      m_dout[k] = 0; m_dr[k] = 1'b0; m_bo[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit rise;
      rise = boot_mode && !m_bo[k];
      m_dr[k] = 1'b0;
      if (in_boot[k]) begin
        if (!boot_mode) in_boot[k] = 1'b0;
        else if (bias_load) begin m_dout[k] = int'(wr_data); m_dr[k] = 1'b1; end
        else if (wr_en && int'(wr_addr) < nn[k]) w[k][wr_addr] = int'(wr_data);
      end else if (boot_mode) begin
        in_boot[k] = 1'b1; scan_pos[k] = -1;
      end else if (snn_clk) begin
        if (scan_pos[k] >= 0 && OvrEn) m_ovr[k] = 1'b1;
        lat[k] = spikes_in; scan_pos[k] = 0;
      end else if (scan_pos[k] >= 0) begin
        if (lat[k][scan_pos[k]]) begin m_dr[k] = 1'b1; m_dout[k] = w[k][scan_pos[k]]; end
        scan_pos[k]++;
        if (scan_pos[k] == nn[k]) scan_pos[k] = -1;
      end
      if (rise) m_ovr[k] = 1'b0;
      m_bo[k] = boot_mode;
    end
  endtask

  task automatic check_outputs();
    chk("dout16", int'(dout0), m_dout[0]);
    chk("data_ready16", int'(dr0), int'(m_dr[0] && !snn_clk));
    chk("boot_out16", int'(bo0), int'(m_bo[0]));
    chk("busy16", int'(busy0), int'(scan_pos[0] >= 0));
    chk("overrun16", int'(ovr0), int'(m_ovr[0]));
    chk("dout12", int'(dout1), m_dout[1]);
    chk("data_ready12", int'(dr1), int'(m_dr[1] && !snn_clk));
    chk("boot_out12", int'(bo1), int'(m_bo[1]));
    chk("busy12", int'(busy1), int'(scan_pos[1] >= 0));
    chk("overrun12", int'(ovr1), int'(m_ovr[1]));
  endtask

  // Inputs are set at posedge+1; outputs checked at posedge+2.
  task automatic cyc();
    #1;
    check_outputs();
    if (dr0) begin ev_cyc0.push_back(cyc_n); ev_val0.push_back(int'(dout0)); end
    if (dr1) begin ev_cyc1.push_back(cyc_n); ev_val1.push_back(int'(dout1)); end
    if (busy0) busy_cnt++;
    @(posedge sys_clk);
    model_step();
    #1;
    cyc_n++;
  endtask

  task automatic clear_events();
    ev_cyc0.delete(); ev_val0.delete(); ev_cyc1.delete(); ev_val1.delete();
    busy_cnt = 0;
  endtask

  task automatic tick_and_run(input logic [15:0] sp, input int n, output int t0);
    clear_events();
    t0 = cyc_n;
    spikes_in = sp; snn_clk = 1'b1;
    cyc();
    snn_clk = 1'b0;
    repeat (n) begin
      spikes_in = 16'($urandom);
      cyc();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1;
    bt[0] = '{wdata: -16'sd5,     exp_dout: -5};
    bt[1] = '{wdata: 16'sd32767,  exp_dout: 32767};
    bt[2] = '{wdata: -16'sd32768, exp_dout: -32768};
    bt[3] = '{wdata: 16'sd123,    exp_dout: 123};

    // Reset state
    model_reset();
    #1;
    check_outputs();
    @(posedge sys_clk);
    #1;
    rst = 1'b0;

    // Boot: weights 10*i, then bias vectors (bias_load overrides wr_en to address 0)
    boot_mode = 1'b1;
    cyc();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'(10 * i);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      bias_load = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = bt[i].wdata;
      cyc();
      bias_load = 1'b0; wr_en = 1'b0;
      #1;
      chk("bias_data_ready", int'(dr0), 1);
      chk("bias_dout", int'(dout0), bt[i].exp_dout);
      chk("bias_boot_out", int'(bo0), 1);
      cyc();
      chk("bias_single_pulse", int'(dr0), 0);
    end
    boot_mode = 1'b0;
    cyc();
    cyc();

    // Tick with 8001: outputs for index 0 and 15 only
    tick_and_run(16'h8001, 20, t0);
    chk("s8001_count", ev_cyc0.size(), 2);
    chk("s8001_cyc0", ev_cyc0.size() > 0 ? ev_cyc0[0] - t0 : -1, 2);
    chk("s8001_val0", ev_val0.size() > 0 ? ev_val0[0] : -1, 0);
    chk("s8001_cyc1", ev_cyc0.size() > 1 ? ev_cyc0[1] - t0 : -1, 17);
    chk("s8001_val1", ev_val0.size() > 1 ? ev_val0[1] : -1, 150);
    chk("s8001_busy", busy_cnt, 16);
    chk("s8001_n12_count", ev_cyc1.size(), 1);

    // Empty tick
    tick_and_run(16'h0000, 20, t0);
    chk("s0_count", ev_cyc0.size(), 0);
    chk("s0_busy", busy_cnt, 16);
    chk("s0_idle", int'(busy0), 0);

    // Re-tick 5 cycles into a scan; index 4's result lands in the tick cycle
    tick_and_run(16'h0110, 5, t0);
    t1 = cyc_n;
    spikes_in = 16'h0002; snn_clk = 1'b1;
    cyc();
    snn_clk = 1'b0;
    repeat (20) cyc();
    chk("ovr_count", ev_cyc0.size(), 1);
    chk("ovr_cyc", ev_cyc0.size() > 0 ? ev_cyc0[0] - t1 : -1, 3);
    chk("ovr_val", ev_val0.size() > 0 ? ev_val0[0] : -1, 10);
    chk("ovr_flag", int'(ovr0), int'(OvrEn));

    // Reset while index 7 is being scanned
    tick_and_run(16'hFFFF, 7, t0);
    rst = 1'b1;
    #1;
    chk("rst_dout", int'(dout0), 0);
    chk("rst_data_ready", int'(dr0), 0);
    chk("rst_boot_out", int'(bo0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_overrun", int'(ovr0), 0);
    chk("rst_busy12", int'(busy1), 0);
    model_reset();
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    clear_events();
    repeat (20) cyc();
    chk("rst_no_resume", ev_cyc0.size(), 0);
    tick_and_run(16'hFFFF, 20, t0);
    chk("rst_weights_count", ev_cyc0.size(), 16);
    chk("rst_weights_w15", ev_val0.size() > 15 ? ev_val0[15] : -1, 150);

    // Out-of-range writes (N_IN=12) and writes outside boot
    boot_mode = 1'b1;
    cyc();
    chk("boot_clears_ovr", int'(ovr0), 0);
    for (int i = 12; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'sd999;
      cyc();
    end
    wr_en = 1'b0; boot_mode = 1'b0;
    cyc();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'sd777;
    cyc();
    wr_en = 1'b0;
    tick_and_run(16'hFFFF, 20, t0);
    chk("n12_count", ev_cyc1.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk("n12_weight", ev_val1.size() > i ? ev_val1[i] : -1, 10 * i);
    end
    chk("n16_w12", ev_val0.size() > 12 ? ev_val0[12] : -1, 999);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(39) == 0) boot_mode = ~boot_mode;
      snn_clk   = ($urandom_range(11) == 0);
      wr_en     = 1'($urandom);
      bias_load = ($urandom_range(7) == 0);
      wr_addr   = 4'($urandom);
      wr_data   = 16'($urandom);
      spikes_in = 16'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/synapse_driver.md
SYNAPSE_DRIVER -- requirements
Module: synapse_driver

Interface
REQ-001 Parameter N_IN, default 16, number of presynaptic inputs driven into one neuron.
REQ-002 Parameter ADDR_W, default $clog2(N_IN), weight address width.
REQ-003 sys_clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 snn_clk  in  1  one-sys_clk-wide timestep tick, shared with the downstream neurons.
REQ-006 boot_mode  in  1  1 = configuration phase (weight/bias loading).
REQ-007 spikes_in  in  N_IN  presynaptic spike vector, sampled on snn_clk.
REQ-008 wr_en  in  1  weight write strobe; honoured only while boot_mode=1.
REQ-009 wr_addr  in  ADDR_W  weight index; writes with wr_addr>=N_IN are dropped.
REQ-010 wr_data  in  16 signed  weight or bias value.
REQ-011 bias_load  in  1  while boot_mode=1, forwards wr_data downstream as the neuron bias.
REQ-012 dout  out  16 signed  value to neuron din; registered.
REQ-013 data_ready  out  1  one-cycle qualifier for dout; registered.
REQ-014 boot_out  out  1  registered boot_mode, cycle-aligned with dout/data_ready.
REQ-015 busy  out  1  high while a scan is in progress.
REQ-016 overrun  out  1  sticky: snn_clk arrived while busy.

Function
REQ-017 FSM states IDLE, BOOT, SCAN; IDLE->BOOT when boot_mode=1; BOOT->IDLE when boot_mode=0.
REQ-018 BOOT: wr_en writes wr_data into weight[wr_addr], one write per cycle, no output.
REQ-019 BOOT: bias_load produces dout=wr_data, data_ready=1, boot_out=1 on the next cycle; bias_load has priority over wr_en in the same cycle (weight not written).
REQ-020 IDLE: snn_clk=1 latches spikes_in, clears index to 0, enters SCAN; data_ready=0 in the tick cycle.
REQ-021 SCAN: one index per cycle, 0..N_IN-1 ascending; if latched spike[i]=1, next cycle dout=weight[i], data_ready=1, else data_ready=0.
REQ-022 SCAN ends after index N_IN-1; return to IDLE; worst-case scan = N_IN cycles, first output 1 cycle after scan entry.
REQ-023 data_ready SHALL never be 1 in a cycle where snn_clk=1.
REQ-024 snn_clk during SCAN: overrun set, current scan aborted, new spikes_in latched, scan restarts at index 0 next cycle.
REQ-025 snn_clk ignored in BOOT; wr_en/bias_load ignored outside BOOT.
REQ-026 boot_mode rising during SCAN aborts the scan (no further data_ready) and enters BOOT.
REQ-027 dout holds its last value when data_ready=0.

Reset
REQ-028 rst asserted: state=IDLE, dout=0, data_ready=0, boot_out=0, busy=0, overrun=0, index=0, latched spikes=0.
REQ-029 Weight storage is not reset; contents are undefined until written.
REQ-030 rst mid-scan: no data_ready after rst asserts; scan not resumed after release.

Configuration
REQ-031 Macro SYNAPSE_OVERRUN_FLAG_EN defined: overrun implemented per REQ-024, cleared only by rst or by rising edge of boot_mode.
REQ-032 Macro undefined: overrun tied 0, no flag register; abort/restart behaviour of REQ-024 unchanged.

Structure
REQ-033 Package snn_pkg holds DATA_W=16, the FSM state enum, and the default N_IN.
REQ-034 Sub-module synapse_weight_rf: N_IN x 16 register file, one sync write port, one async read port.
REQ-035 FSM, index counter, spike latch and output registers stay in synapse_driver.

Verification
REQ-036 Boot: write weights 0..15 = 10*i, bias_load with wr_data=-5 -> one data_ready, dout=-5, boot_out=1.
REQ-037 Tick with spikes_in=16'h8001 -> data_ready exactly twice: dout=0 (cycle 2), dout=150 (cycle 17); busy for 16 cycles.
REQ-038 Tick with spikes_in=0 -> no data_ready, busy 16 cycles, return to IDLE.
REQ-039 Second tick 5 cycles into scan -> overrun=1 (with macro), scan restarts at index 0 with new vector, no data_ready in tick cycle.
REQ-040 rst pulse at scan index 7 -> all outputs 0 immediately, no further data_ready; weights preserved in a following scan.
REQ-041 wr_en with wr_addr>=N_IN (N_IN=12) -> no weight changes; wr_en with boot_mode=0 -> ignored.
